sprite_compositor: RTL and testbench
====================================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of sprite channels.
REQ-002 SHALL have parameter SPRITE_W, default 150, sprite width in pixels.
REQ-003 SHALL have parameter SPRITE_H, default 157, sprite height in pixels.
REQ-004 SHALL have parameter NUM_STATES, default 6, number of valid animation states per player.
REQ-005 SHALL have parameter TRANSPARENT, default 8'hE3, the colour key.
REQ-006 SHALL have parameter BG_COLOR, default 8'h3B, the output when no sprite is visible.
REQ-007 clk  in  1  single clock for all logic; the block SHALL use only this clock.
REQ-008 rst  in  1  reset, synchronous and active-high.
REQ-009 frame_start  in  1  one-cycle pulse at the first pixel of each frame.
REQ-010 current_pixel_x, current_pixel_y  in  10 each  pixel being scanned.
REQ-011 posx, posy  in  NUM_PLAYERS*10 each  packed top-left positions; player i occupies bits [10i+9:10i].
REQ-012 currentstate  in  NUM_PLAYERS*4  packed animation state per player.
REQ-013 rom_addr  out  NUM_PLAYERS*15  packed per-player ROM address, combinational from the current pixel.
REQ-014 rom_state  out  NUM_PLAYERS*4  packed shadowed state per player, which selects the external ROM image.
REQ-015 rom_q  in  NUM_PLAYERS*8  packed ROM data, valid exactly 1 cycle after rom_addr.
REQ-016 data  out  8  composited pixel colour.
REQ-017 visible_flag  out  1  high when data comes from an opaque sprite pixel.
REQ-018 top_player  out  clog2(NUM_PLAYERS)  index of the player that supplied data; 0 when not visible.
REQ-019 collision_frame  out  1  high if two or more opaque sprite pixels coincided anywhere in the previous frame.

Function
REQ-020 Shadowing: on frame_start, posx, posy and currentstate SHALL be copied into shadow registers; all hit tests and addresses SHALL use the shadows, so mid-frame input changes have no visible effect until the next frame.
REQ-021 The frame_start pixel itself SHALL be tested against the newly captured shadow values (bypass).
REQ-022 Hit test per player: x >= posx and x < posx+SPRITE_W, and likewise for y. Compare in 11 bits so that posx+SPRITE_W > 1023 does not wrap.
REQ-023 Address per player: (y-posy)*SPRITE_W + (x-posx), 15 bits. Address 0 is valid. When the hit test fails, the address SHALL be driven to 0.
REQ-024 A player SHALL be ineligible for the pixel if its shadowed state >= NUM_STATES.
REQ-025 Pipeline stage 1: per-player hit&eligible bits SHALL be registered alongside the issued address, aligned with rom_q.
REQ-026 Pipeline stage 2: a player is opaque when its stage-1 hit bit is set and its rom_q != TRANSPARENT.
  - data SHALL take the rom_q of the highest-index opaque player.
  - visible_flag SHALL be 1 and top_player SHALL be that player's index.
  - If no player is opaque: data=BG_COLOR, visible_flag=0, top_player=0.
REQ-027 Total latency SHALL be 2 cycles: from current_pixel_x/y to data, visible_flag and top_player.
REQ-028 Collision: a sticky bit SHALL set whenever 2 or more players are opaque in stage 2.
  - On frame_start, collision_frame SHALL take the sticky value, including a collision in that same cycle.
  - The sticky bit SHALL then clear.
REQ-029 A transparent pixel SHALL never set the collision bit or win priority.

Reset
REQ-030 On rst, these SHALL all be 0: shadow registers, pipeline hit bits, sticky collision bit, collision_frame, visible_flag, top_player. data SHALL be BG_COLOR.
REQ-031 rst SHALL override a simultaneous frame_start.
REQ-032 rst asserted mid-frame SHALL discard in-flight pipeline contents; outputs SHALL be at reset values the cycle after rst is sampled.
REQ-033 Until the first frame_start after reset, shadows SHALL stay 0; players sit at (0,0) in state 0.

Structure
REQ-034 A shared package sprite_pkg SHALL hold:
  - COORD_W=10, ADDR_W=15, PIXEL_W=8, STATE_W=4
  - default TRANSPARENT and BG_COLOR
  - state encodings: IDLE=0, WALK=1, WALKBACK=2, ATTACKSTART=3, ATTACKEND=4, ATTACKPULL=5
REQ-035 There SHALL be one sub-module, sprite_locator, which does the combinational per-player hit test and address calculation. It SHALL be instantiated NUM_PLAYERS times via generate.
REQ-036 The ROM images and state muxing SHALL stay outside this block.

Verification
REQ-037 Single sprite: P0 at (100,50), frame_start, pixel (100,50), rom_q0=8'h1C -> 2 cycles later data=8'h1C, visible_flag=1, top_player=0; rom_addr0 was 0 in the issue cycle.
REQ-038 Priority: P0 and P1 both at (200,100), pixel (210,105), rom_q0=8'h11, rom_q1=8'h22 -> rom_addr=760 for both; data=8'h22, top_player=1; collision_frame=1 after the next frame_start.
REQ-039 Transparency: same overlap with rom_q1=8'hE3, rom_q0=8'h11 -> data=8'h11, top_player=0; no collision recorded for the frame.
REQ-040 Edges and wrap: posx=900, pixel x=1023 -> hit. pixel x=899 -> miss. pixel (249,206) with sprite at (100,50) -> addr 23549. pixel y=207 -> miss, data=8'h3B.
REQ-041 Shadowing: change posx from 100 to 300 mid-frame -> hits still computed at 100 until the next frame_start; currentstate=7 -> player invisible.
REQ-042 Reset: assert rst during an active overlap with a frame_start pulse -> next cycle data=8'h3B, visible_flag=0, collision_frame=0, shadows 0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared widths, colour keys and animation state codes
// for the sprite compositing path.
package sprite_pkg;

  localparam int COORD_W = 10;
  localparam int ADDR_W  = 15;
  localparam int PIXEL_W = 8;
  localparam int STATE_W = 4;

  localparam logic [PIXEL_W-1:0] TRANSPARENT_DEF = 8'hE3;
  localparam logic [PIXEL_W-1:0] BG_COLOR_DEF    = 8'h3B;

  typedef enum logic [STATE_W-1:0] {
    IDLE        = 4'd0,
    WALK        = 4'd1,
    WALKBACK    = 4'd2,
    ATTACKSTART = 4'd3,
    ATTACKEND   = 4'd4,
    ATTACKPULL  = 4'd5
  } anim_state_e;

endpackage

// File: rtl/sprite_locator.sv
// Per-player hit test and sprite ROM address
// for the pixel currently being scanned.
module sprite_locator
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = 150,
  parameter int SPRITE_H = 157
) (
  input  logic [COORD_W-1:0] px_i,
  input  logic [COORD_W-1:0] py_i,
  input  logic [COORD_W-1:0] posx_i,
  input  logic [COORD_W-1:0] posy_i,
  output logic               hit_o,
  output logic [ADDR_W-1:0]  addr_o
);

  localparam logic [COORD_W:0] W_EXT = (COORD_W+1)'(SPRITE_W);
  localparam logic [COORD_W:0] H_EXT = (COORD_W+1)'(SPRITE_H);

  logic [COORD_W:0]   x_ext;
  logic [COORD_W:0]   y_ext;
  logic [COORD_W:0]   bx_ext;
  logic [COORD_W:0]   by_ext;
  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;
  logic               hit_x;
  logic               hit_y;

  // One extra bit keeps pos+size from wrapping past the screen edge
  assign x_ext  = {1'b0, px_i};
  assign y_ext  = {1'b0, py_i};
  assign bx_ext = {1'b0, posx_i};
  assign by_ext = {1'b0, posy_i};

  assign hit_x = (x_ext >= bx_ext) && (x_ext < bx_ext + W_EXT);
  assign hit_y = (y_ext >= by_ext) && (y_ext < by_ext + H_EXT);
  assign hit_o = hit_x && hit_y;

  assign dx = px_i - posx_i;
  assign dy = py_i - posy_i;

  assign addr_o = hit_o
    ? ADDR_W'(dy) * ADDR_W'(SPRITE_W) + ADDR_W'(dx)
    : '0;

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor: shadowed positions, ROM fetch,
// priority/transparency merge and per-frame collision flag.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int                 NUM_PLAYERS = 2,
  parameter int                 SPRITE_W    = 150,
  parameter int                 SPRITE_H    = 157,
  parameter int                 NUM_STATES  = 6,
  parameter logic [PIXEL_W-1:0] TRANSPARENT = TRANSPARENT_DEF,
  parameter logic [PIXEL_W-1:0] BG_COLOR    = BG_COLOR_DEF,
  localparam int TP_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_start,
  input  logic [COORD_W-1:0]             current_pixel_x,
  input  logic [COORD_W-1:0]             current_pixel_y,
  input  logic [NUM_PLAYERS*COORD_W-1:0] posx,
  input  logic [NUM_PLAYERS*COORD_W-1:0] posy,
  input  logic [NUM_PLAYERS*STATE_W-1:0] currentstate,
  output logic [NUM_PLAYERS*ADDR_W-1:0]  rom_addr,
  output logic [NUM_PLAYERS*STATE_W-1:0] rom_state,
  input  logic [NUM_PLAYERS*PIXEL_W-1:0] rom_q,
  output logic [PIXEL_W-1:0]             data,
  output logic                           visible_flag,
  output logic [TP_W-1:0]                top_player,
  output logic                           collision_frame
);

  localparam int NP = NUM_PLAYERS;

  logic [NP*COORD_W-1:0] posx_q, posx_d;
  logic [NP*COORD_W-1:0] posy_q, posy_d;
  logic [NP*STATE_W-1:0] state_q, state_d;

  logic [NP-1:0] hit;
  logic [NP-1:0] elig;
  logic [NP-1:0] hit_q, hit_d;

  logic [PIXEL_W-1:0] data_q, data_d;
  logic               vis_q, vis_d;
  logic [TP_W-1:0]    top_q, top_d;
  logic               sticky_q, sticky_d;
  logic               coll_q, coll_d;
  logic               seen;
  logic               collide;

  // The next-state shadow doubles as the bypass for the frame_start pixel
  assign posx_d  = frame_start ? posx : posx_q;
  assign posy_d  = frame_start ? posy : posy_q;
  assign state_d = frame_start ? currentstate : state_q;

  assign rom_state = state_d;

  for (genvar i = 0; i < NP; i++) begin : g_loc
    sprite_locator #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H)
    ) u_loc (
      .px_i   (current_pixel_x),
      .py_i   (current_pixel_y),
      .posx_i (posx_d[i*COORD_W +: COORD_W]),
      .posy_i (posy_d[i*COORD_W +: COORD_W]),
      .hit_o  (hit[i]),
      .addr_o (rom_addr[i*ADDR_W +: ADDR_W])
    );

    assign elig[i] =
      int'(state_d[i*STATE_W +: STATE_W]) < NUM_STATES;
  end

  assign hit_d = hit & elig;

  // Highest-index opaque player wins; a second opaque one flags a collision
  always_comb begin
    data_d  = BG_COLOR;
    vis_d   = 1'b0;
    top_d   = '0;
    seen    = 1'b0;
    collide = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (hit_q[i] &&
          rom_q[i*PIXEL_W +: PIXEL_W] != TRANSPARENT) begin
        collide = collide | seen;
        seen    = 1'b1;
        data_d  = rom_q[i*PIXEL_W +: PIXEL_W];
        vis_d   = 1'b1;
        top_d   = TP_W'(i);
      end
    end
  end

  always_comb begin
    coll_d   = coll_q;
    sticky_d = sticky_q | collide;
    if (frame_start) begin
      coll_d   = sticky_q | collide;
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      posx_q   <= '0;
      posy_q   <= '0;
      state_q  <= '0;
      hit_q    <= '0;
      data_q   <= BG_COLOR;
      vis_q    <= 1'b0;
      top_q    <= '0;
      sticky_q <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      posx_q   <= posx_d;
      posy_q   <= posy_d;
      state_q  <= state_d;
      hit_q    <= hit_d;
      data_q   <= data_d;
      vis_q    <= vis_d;
      top_q    <= top_d;
      sticky_q <= sticky_d;
      coll_q   <= coll_d;
    end
  end

  assign data            = data_q;
  assign visible_flag    = vis_q;
  assign top_player      = top_q;
  assign collision_frame = coll_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: addressing, priority,
// transparency, edges, shadowing, collision and reset.
module tb_sprite_compositor;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic [9:0]  px;
  logic [9:0]  py;
  logic [19:0] posx;
  logic [19:0] posy;
  logic [7:0]  cstate;
  logic [29:0] rom_addr;
  logic [7:0]  rom_state;
  logic [15:0] rom_q;
  logic [7:0]  data;
  logic        vis;
  logic        top;
  logic        coll;

  int n_cmp = 0;
  int n_bad = 0;

  sprite_compositor dut (
    .clk             (clk),
    .rst             (rst),
    .frame_start     (frame_start),
    .current_pixel_x (px),
    .current_pixel_y (py),
    .posx            (posx),
    .posy            (posy),
    .currentstate    (cstate),
    .rom_addr        (rom_addr),
    .rom_state       (rom_state),
    .rom_q           (rom_q),
    .data            (data),
    .visible_flag    (vis),
    .top_player      (top),
    .collision_frame (coll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic pix(input logic [9:0] x,
                     input logic [9:0] y);
    px = x;
    py = y;
    #1;
  endtask

  task automatic park();
    px    = 10'd1023;
    py    = 10'd1023;
    rom_q = 16'hE3E3;
  endtask

  initial begin
    rst         = 1'b1;
    frame_start = 1'b0;
    posx        = '0;
    posy        = '0;
    cstate      = '0;
    park();
    tick();
    tick();
    chk("rst_data", 32'(data), 32'h3B);
    chk("rst_vis", 32'(vis), 32'd0);
    chk("rst_top", 32'(top), 32'd0);
    chk("rst_coll", 32'(coll), 32'd0);
    rst = 1'b0;

    // Before any frame_start the shadows hold (0,0)
    posx = {10'd500, 10'd100};
    posy = {10'd400, 10'd50};
    pix(10'd5, 10'd2);
    chk("preframe_addr0", 32'(rom_addr[14:0]), 32'd305);
    chk("preframe_state", 32'(rom_state), 32'd0);

    // Single sprite at (100,50), frame_start pixel bypass
    frame_start = 1'b1;
    pix(10'd100, 10'd50);
    chk("single_addr0", 32'(rom_addr[14:0]), 32'd0);
    tick();
    rom_q = {8'hE3, 8'h1C};
    tick();
    chk("single_data", 32'(data), 32'h1C);
    chk("single_vis", 32'(vis), 32'd1);
    chk("single_top", 32'(top), 32'd0);
    park();

    // Bottom-right corner of the sprite
    pix(10'd249, 10'd206);
    chk("corner_addr0", 32'(rom_addr[14:0]), 32'd23549);
    tick();
    rom_q = {8'hE3, 8'h5A};
    tick();
    chk("corner_data", 32'(data), 32'h5A);
    pix(10'd249, 10'd207);
    chk("below_addr0", 32'(rom_addr[14:0]), 32'd0);
    tick();
    tick();
    chk("below_data", 32'(data), 32'h3B);
    park();

    // Mid-frame posx change stays invisible until frame_start
    posx = {10'd500, 10'd300};
    pix(10'd110, 10'd50);
    chk("shadow_addr0", 32'(rom_addr[14:0]), 32'd10);
    tick();
    rom_q = {8'hE3, 8'h1C};
    tick();
    chk("shadow_data", 32'(data), 32'h1C);
    rom_q = 16'hE3E3;
    pix(10'd310, 10'd50);
    chk("shadow_miss", 32'(rom_addr[14:0]), 32'd0);
    frame_start = 1'b1;
    cstate      = {4'd0, 4'd7};
    #1;
    chk("newpos_addr0", 32'(rom_addr[14:0]), 32'd10);
    chk("newpos_state", 32'(rom_state), 32'h07);
    tick();
    rom_q = {8'hE3, 8'h1C};
    tick();
    chk("badstate_data", 32'(data), 32'h3B);
    chk("badstate_vis", 32'(vis), 32'd0);
    park();

    // Overlap priority: player 1 wins, collision recorded
    posx        = {10'd200, 10'd200};
    posy        = {10'd100, 10'd100};
    cstate      = '0;
    frame_start = 1'b1;
    pix(10'd210, 10'd105);
    chk("prio_addr0", 32'(rom_addr[14:0]), 32'd760);
    chk("prio_addr1", 32'(rom_addr[29:15]), 32'd760);
    tick();
    rom_q = {8'h22, 8'h11};
    tick();
    chk("prio_data", 32'(data), 32'h22);
    chk("prio_top", 32'(top), 32'd1);
    chk("prio_vis", 32'(vis), 32'd1);
    park();
    frame_start = 1'b1;
    tick();
    chk("prio_coll", 32'(coll), 32'd1);

    // Transparent top player: lower player shows, no collision
    pix(10'd210, 10'd105);
    tick();
    rom_q = {8'hE3, 8'h11};
    tick();
    chk("transp_data", 32'(data), 32'h11);
    chk("transp_top", 32'(top), 32'd0);
    park();
    frame_start = 1'b1;
    tick();
    chk("transp_coll", 32'(coll), 32'd0);

    // Collision in the frame_start cycle itself
    pix(10'd210, 10'd105);
    tick();
    rom_q       = {8'h22, 8'h11};
    frame_start = 1'b1;
    tick();
    chk("samecyc_coll", 32'(coll), 32'd1);
    chk("samecyc_data", 32'(data), 32'h22);
    park();
    frame_start = 1'b1;
    tick();
    chk("cleared_coll", 32'(coll), 32'd0);

    // Right screen edge: posx+150 must not wrap
    posx        = {10'd200, 10'd900};
    posy        = {10'd100, 10'd0};
    frame_start = 1'b1;
    pix(10'd1023, 10'd0);
    chk("edge_addr0", 32'(rom_addr[14:0]), 32'd123);
    tick();
    rom_q = {8'hE3, 8'h33};
    tick();
    chk("edge_data", 32'(data), 32'h33);
    chk("edge_vis", 32'(vis), 32'd1);
    pix(10'd899, 10'd0);
    chk("left_addr0", 32'(rom_addr[14:0]), 32'd0);
    tick();
    tick();
    chk("left_data", 32'(data), 32'h3B);
    park();

    // Reset together with frame_start during an overlap
    posx        = {10'd200, 10'd200};
    posy        = {10'd100, 10'd100};
    frame_start = 1'b1;
    pix(10'd210, 10'd105);
    tick();
    rom_q       = {8'h22, 8'h11};
    rst         = 1'b1;
    frame_start = 1'b1;
    tick();
    chk("rst2_data", 32'(data), 32'h3B);
    chk("rst2_vis", 32'(vis), 32'd0);
    chk("rst2_top", 32'(top), 32'd0);
    chk("rst2_coll", 32'(coll), 32'd0);
    rst = 1'b0;
    pix(10'd5, 10'd2);
    chk("rst2_addr0", 32'(rom_addr[14:0]), 32'd305);
    chk("rst2_state", 32'(rom_state), 32'd0);
    tick();
    chk("flush_data", 32'(data), 32'h3B);
    park();
    frame_start = 1'b1;
    tick();
    chk("rst2_frame_coll", 32'(coll), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
